// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - two-requester arbiter for one shared ALU with a tagged, registered response buffer
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins every tie.
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [OP_WIDTH-1:0]   req0_op,
  input  logic [DATA_WIDTH-1:0] req0_a,
  input  logic [DATA_WIDTH-1:0] req0_b,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [OP_WIDTH-1:0]   req1_op,
  input  logic [DATA_WIDTH-1:0] req1_a,
  input  logic [DATA_WIDTH-1:0] req1_b,
  output logic                  req1_ready,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_Result,
  input  logic                  alu_Overflow,
  input  logic                  alu_CarryOut,
  input  logic                  alu_Zero,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_id,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  rsp_overflow,
  output logic                  rsp_carryout,
  output logic                  rsp_zero,
  output logic                  rsp_err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t state;
  logic   last_gnt;
  logic   can_accept;
  logic   gnt0;
  logic   gnt1;
  logic   accept;
  logic   op_illegal;

  assign rsp_valid  = (state == FULL);
  assign can_accept = (state == EMPTY) | rsp_ready;
  assign accept     = (gnt0 | gnt1) & can_accept;
  assign req0_ready = gnt0 & can_accept;
  assign req1_ready = gnt1 & can_accept;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (req0_valid && req1_valid) begin
`ifdef ALU_ARB_RR_EN
      gnt0 = last_gnt;
      gnt1 = ~last_gnt;
`else
      gnt0 = 1'b1;
`endif
    end else begin
      gnt0 = req0_valid;
      gnt1 = req1_valid;
    end
  end

  // Idle drive is an AND of zeros so the ALU sits in a quiet state.
  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_op = '0;
    if (gnt1) begin
      alu_A  = req1_a;
      alu_B  = req1_b;
      alu_op = req1_op;
    end else if (gnt0) begin
      alu_A  = req0_a;
      alu_B  = req0_b;
      alu_op = req0_op;
    end
  end

  always_comb begin
    op_illegal = 1'b0;
    case (alu_op)
      OP_WIDTH'(8), OP_WIDTH'(13), OP_WIDTH'(14), OP_WIDTH'(15): op_illegal = 1'b1;
      default: op_illegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= EMPTY;
      last_gnt     <= 1'b1;
      rsp_id       <= 1'b0;
      rsp_result   <= '0;
      rsp_overflow <= 1'b0;
      rsp_carryout <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_err      <= 1'b0;
    end else begin
      // Tracked in both builds so the last owner stays observable for debug.
      last_gnt <= accept ? gnt1 : last_gnt;
      if (accept) begin
        state  <= FULL;
        rsp_id <= gnt1;
        if (op_illegal) begin
          rsp_result   <= '0;
          rsp_overflow <= 1'b0;
          rsp_carryout <= 1'b0;
          rsp_zero     <= 1'b0;
          rsp_err      <= 1'b1;
        end else begin
          rsp_result   <= alu_Result;
          rsp_overflow <= alu_Overflow;
          rsp_carryout <= alu_CarryOut;
          rsp_zero     <= alu_Zero;
          rsp_err      <= 1'b0;
        end
      end else if (state == FULL && rsp_ready) begin
        state <= EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed bench for alu_share_arbiter with a transaction-level model and a stand-in ALU
module tb_alu_share_arbiter;
  localparam int DW = 32;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid, req1_valid, req0_ready, req1_ready;
  logic [OW-1:0] req0_op, req1_op, alu_op;
  logic [DW-1:0] req0_a, req0_b, req1_a, req1_b, alu_A, alu_B, alu_Result;
  logic          alu_Overflow, alu_CarryOut, alu_Zero;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_overflow, rsp_carryout, rsp_zero, rsp_err;
  logic [DW-1:0] rsp_result;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic          ovf;
    logic          cout;
    logic          zero;
    logic [DW-1:0] res;
  } alu_out_t;

  // Reference ALU; ops outside the legal set return junk so masking is visible.
  function automatic alu_out_t alu_fn(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    alu_out_t o;
    logic [DW:0] wide;
    o = '0;
    case (op)
      4'd0:  o.res = a & b;
      4'd1:  o.res = a | b;
      4'd2: begin
        wide   = {1'b0, a} + {1'b0, b};
        o.res  = wide[DW-1:0];
        o.cout = wide[DW];
        o.ovf  = (a[DW-1] == b[DW-1]) && (o.res[DW-1] != a[DW-1]);
      end
      4'd3:  o.res = a ^ b;
      4'd4:  o.res = a << b[4:0];
      4'd5:  o.res = a >> b[4:0];
      4'd6: begin
        wide   = {1'b0, a} + {1'b0, ~b} + 1;
        o.res  = wide[DW-1:0];
        o.cout = wide[DW];
        o.ovf  = (a[DW-1] != b[DW-1]) && (o.res[DW-1] != a[DW-1]);
      end
      4'd7:  o.res = {{(DW-1){1'b0}}, $signed(a) < $signed(b)};
      4'd9:  o.res = $unsigned($signed(a) >>> b[4:0]);
      4'd10: o.res = {{(DW-1){1'b0}}, a < b};
      4'd11: o.res = {b[15:0], 16'h0};
      4'd12: o.res = ~(a | b);
      default: begin
        o.res  = a | b | 32'h1;
        o.ovf  = 1'b1;
        o.cout = 1'b1;
      end
    endcase
    o.zero = (o.res == '0);
    return o;
  endfunction

  alu_out_t alu_now;
  always_comb begin
    alu_now      = alu_fn(alu_op, alu_A, alu_B);
    alu_Result   = alu_now.res;
    alu_Overflow = alu_now.ovf;
    alu_CarryOut = alu_now.cout;
    alu_Zero     = alu_now.zero;
  end

  alu_share_arbiter #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .alu_A(alu_A), .alu_B(alu_B), .alu_op(alu_op),
    .alu_Result(alu_Result), .alu_Overflow(alu_Overflow), .alu_CarryOut(alu_CarryOut), .alu_Zero(alu_Zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_overflow(rsp_overflow), .rsp_carryout(rsp_carryout), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Model of the response buffer and round-robin history.
  logic          m_valid;
  logic          m_id;
  logic          m_err;
  alu_out_t      m_out;
  int            m_last;
  logic          s_r0, s_r1;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic rr,
                      input logic v0, input logic [OW-1:0] o0, input logic [DW-1:0] a0, input logic [DW-1:0] b0,
                      input logic v1, input logic [OW-1:0] o1, input logic [DW-1:0] a1, input logic [DW-1:0] b1);
    int   g;
    logic can;
    logic [OW-1:0] gop;
    rst = r; rsp_ready = rr;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    @(negedge clk);
    g = -1;
    if (v0 && v1) begin
`ifdef ALU_ARB_RR_EN
      g = (m_last == 0) ? 1 : 0;
`else
      g = 0;
`endif
    end else if (v0) g = 0;
    else if (v1) g = 1;
    can = !m_valid || rr;
    chk("req0_ready", req0_ready, (g == 0) && can);
    chk("req1_ready", req1_ready, (g == 1) && can);
    chk("alu_A", alu_A, (g == 0) ? a0 : (g == 1) ? a1 : '0);
    chk("alu_B", alu_B, (g == 0) ? b0 : (g == 1) ? b1 : '0);
    gop = (g == 0) ? o0 : (g == 1) ? o1 : '0;
    chk("alu_op", alu_op, gop);
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_result", rsp_result, m_out.res);
      chk("rsp_overflow", rsp_overflow, m_out.ovf);
      chk("rsp_carryout", rsp_carryout, m_out.cout);
      chk("rsp_zero", rsp_zero, m_out.zero);
      chk("rsp_err", rsp_err, m_err);
    end
    s_r0 = req0_ready;
    s_r1 = req1_ready;
    if (r) begin
      m_valid = 0; m_last = 1;
    end else if (g >= 0 && can) begin
      m_valid = 1;
      m_id    = (g == 1);
      m_last  = g;
      m_err   = (gop == 4'd8) || (gop >= 4'd13);
      m_out   = m_err ? '0 : ((g == 0) ? alu_fn(o0, a0, b0) : alu_fn(o1, a1, b1));
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; rsp_ready = 1'b0;
    req0_valid = 0; req0_op = '0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = '0; req1_a = '0; req1_b = '0;
    m_valid = 0; m_id = 0; m_err = 0; m_out = '0; m_last = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_id", rsp_id, 0);
    chk("reset rsp_result", rsp_result, 0);
    chk("reset flags", {rsp_overflow, rsp_carryout, rsp_zero, rsp_err}, 0);

    // 1: single ADD
    step(0, 1, 1, 4'd2, 32'd5, 32'd3, 0, 4'd0, 0, 0);
    chk("t1 req0_ready", s_r0, 1);
    chk("t1 rsp_valid", rsp_valid, 1);
    chk("t1 rsp_id", rsp_id, 0);
    chk("t1 rsp_result", rsp_result, 32'd8);
    chk("t1 rsp_err", rsp_err, 0);

    // 2: req1 SUB going negative
    step(0, 1, 0, 4'd0, 0, 0, 1, 4'd6, 32'd3, 32'd5);
    chk("t2 rsp_result", rsp_result, 32'hFFFF_FFFE);
    chk("t2 rsp_id", rsp_id, 1);
    chk("t2 rsp_overflow", rsp_overflow, 0);

    // 3: tie for four cycles
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 4'd2, 32'd1, 32'd1, 1, 4'd2, 32'd2, 32'd2);
`ifdef ALU_ARB_RR_EN
      chk("t3 req0_ready", s_r0, (i % 2) == 0);
      chk("t3 req1_ready", s_r1, (i % 2) == 1);
      chk("t3 rsp_id", rsp_id, (i % 2) == 1);
`else
      chk("t3 req0_ready", s_r0, 1);
      chk("t3 req1_ready", s_r1, 0);
      chk("t3 rsp_id", rsp_id, 0);
`endif
    end

    // 4: backpressure then release
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 4'd1, 32'hF0, 32'h0F, 0, 4'd0, 0, 0);
      chk("t4 req0_ready", s_r0, 0);
      chk("t4 rsp_valid", rsp_valid, 1);
`ifdef ALU_ARB_RR_EN
      chk("t4 hold result", rsp_result, 32'd4);
`else
      chk("t4 hold result", rsp_result, 32'd2);
`endif
    end
    step(0, 1, 1, 4'd1, 32'hF0, 32'h0F, 0, 4'd0, 0, 0);
    chk("t4 release ready", s_r0, 1);
    chk("t4 rsp_result", rsp_result, 32'hFF);

    // 5: illegal ops on each requester
    step(0, 1, 1, 4'd8, 32'd1, 32'd1, 0, 4'd0, 0, 0);
    chk("t5 rsp_err", rsp_err, 1);
    chk("t5 rsp_result", rsp_result, 0);
    step(0, 1, 0, 4'd0, 0, 0, 1, 4'd15, 32'd7, 32'd9);
    chk("t5b rsp_err", rsp_err, 1);
    chk("t5b flags", {rsp_overflow, rsp_carryout, rsp_zero}, 0);
    step(0, 1, 0, 4'd0, 0, 0, 1, 4'd12, 32'd0, 32'd0);
    chk("t5c nor", rsp_result, 32'hFFFF_FFFF);
    chk("t5c rsp_err", rsp_err, 0);

    // drain without accept, then ADD overflow corner
    step(0, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0);
    chk("drain rsp_valid", rsp_valid, 0);
    step(0, 1, 1, 4'd2, 32'h7FFF_FFFF, 32'd1, 0, 4'd0, 0, 0);
    chk("ovf add", {rsp_overflow, rsp_carryout, rsp_zero}, 3'b100);
    step(0, 1, 0, 4'd0, 0, 0, 1, 4'd6, 32'd9, 32'd9);
    chk("sub zero", {rsp_overflow, rsp_carryout, rsp_zero}, 3'b011);

    // 6: reset while full with both valid; first tie afterwards goes to 0
    step(0, 0, 1, 4'd2, 32'd4, 32'd4, 0, 4'd0, 0, 0);
    step(1, 0, 1, 4'd2, 32'd4, 32'd4, 1, 4'd3, 32'd6, 32'd5);
    chk("t6 rsp_valid", rsp_valid, 0);
    step(0, 0, 1, 4'd2, 32'd4, 32'd4, 1, 4'd3, 32'd6, 32'd5);
    chk("t6 req0_ready", s_r0, 1);
    chk("t6 req1_ready", s_r1, 0);
    chk("t6 rsp_result", rsp_result, 32'd8);
    step(0, 1, 0, 4'd0, 0, 0, 0, 4'd0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
